// File: rtl/timer_ctrl.sv
// timer_ctrl: mm:ss countdown sequencer with IDLE/RUN/PAUSE/ALARM FSM and CLK_DIV tick divider.
// Define TMR_CTRL_RESTART_EN to let start in ALARM reload the last run preset.
module timer_ctrl #(
    parameter int CLK_DIV     = 100000000,
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       tmrreset,
    input  logic       btn_start,
    input  logic       btn_sec,
    input  logic       btn_min,
    input  logic       btn_clr,
    output logic [5:0] tmrs,
    output logic [5:0] tmrm,
    output logic [1:0] state,
    output logic       alarm,
    output logic       done
);
    localparam int DW = $clog2(CLK_DIV);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;
    state_t r_state, w_state;
    logic [5:0] r_s, r_m, w_s, w_m;
    logic [DW-1:0] r_div, w_div;
    logic [7:0] r_acnt, w_acnt;
    logic r_done, w_done;
    logic [3:0] r_prev, w_ev;
    logic w_clr, w_start, w_min, w_sec, w_tick;
`ifdef TMR_CTRL_RESTART_EN
    logic [11:0] r_pre, w_pre;
`endif
    // Event bits ordered {clr, start, min, sec}; one-hot by priority.
    assign w_ev    = {btn_clr, btn_start, btn_min, btn_sec} & ~r_prev;
    assign w_clr   = w_ev[3];
    assign w_start = w_ev[2] & ~w_ev[3];
    assign w_min   = w_ev[1] & ~|w_ev[3:2];
    assign w_sec   = w_ev[0] & ~|w_ev[3:1];
    assign w_tick  = r_div == DW'(CLK_DIV - 1);
    assign tmrs  = r_s;
    assign tmrm  = r_m;
    assign state = r_state;
    assign alarm = r_state == ALARM;
    assign done  = r_done;
    always_ff @(posedge clk) begin
        if (tmrreset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_m     <= '0;
            r_div   <= '0;
            r_acnt  <= '0;
            r_done  <= 1'b0;
            r_prev  <= '0;
`ifdef TMR_CTRL_RESTART_EN
            r_pre   <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_s     <= w_s;
            r_m     <= w_m;
            r_div   <= w_div;
            r_acnt  <= w_acnt;
            r_done  <= w_done;
            r_prev  <= {btn_clr, btn_start, btn_min, btn_sec};
`ifdef TMR_CTRL_RESTART_EN
            r_pre   <= w_pre;
`endif
        end
    end
    always_comb begin
        w_state = r_state;
        w_s     = r_s;
        w_m     = r_m;
        w_acnt  = r_acnt;
        w_done  = 1'b0;
        w_div   = (r_state == RUN || r_state == ALARM) ? (w_tick ? '0 : r_div + 1'b1) : r_div;
`ifdef TMR_CTRL_RESTART_EN
        w_pre   = r_pre;
`endif
        case (r_state)
            IDLE: begin
                w_div = '0;
                if (w_clr) begin
                    w_s = '0;
                    w_m = '0;
                end else if (w_start) begin
                    if ({r_m, r_s} != '0) begin
                        w_state = RUN;
`ifdef TMR_CTRL_RESTART_EN
                        w_pre   = {r_m, r_s};
`endif
                    end
                end else if (w_min) begin
                    w_m = (r_m == 6'd59) ? 6'd0 : r_m + 6'd1;
                end else if (w_sec) begin
                    w_s = (r_s == 6'd59) ? 6'd0 : r_s + 6'd1;
                    w_m = (r_s != 6'd59) ? r_m : (r_m == 6'd59) ? 6'd0 : r_m + 6'd1;
                end
            end
            RUN: begin
                if (w_clr) begin
                    w_state = IDLE;
                    w_s     = '0;
                    w_m     = '0;
                    w_div   = '0;
                end else if (w_start) begin
                    w_state = PAUSE;
                    w_div   = r_div;
                end else if (w_tick) begin
                    w_s = (r_s != '0) ? r_s - 6'd1 : 6'd59;
                    w_m = (r_s != '0) ? r_m : r_m - 6'd1;
                    if (r_m == '0 && r_s == 6'd1) begin
                        w_state = ALARM;
                        w_done  = 1'b1;
                        w_acnt  = '0;
                    end
                end
            end
            PAUSE: begin
                if (w_clr) begin
                    w_state = IDLE;
                    w_s     = '0;
                    w_m     = '0;
                    w_div   = '0;
                end else if (w_start) begin
                    w_state = RUN;
                    w_div   = '0;
                end
            end
            ALARM: begin
                w_s = '0;
                w_m = '0;
`ifdef TMR_CTRL_RESTART_EN
                if (w_start) begin
                    w_state    = RUN;
                    {w_m, w_s} = r_pre;
                    w_div      = '0;
                    w_acnt     = '0;
                end else
`endif
                if (|w_ev || (w_tick && r_acnt == 8'(ALARM_TICKS - 1))) begin
                    w_state = IDLE;
                    w_div   = '0;
                    w_acnt  = '0;
                end else if (w_tick) begin
                    w_acnt = r_acnt + 8'd1;
                end
            end
            default: w_state = IDLE;
        endcase
    end
endmodule
